// File: rtl/backing_ram.sv
// Word-addressed 1024 x 10-bit main-memory model behind the write-back cache.
// Each access is captured, waits LATENCY cycles, then pulses mem_ready_o for one cycle.
module backing_ram #(
    parameter int LATENCY      = 2,
    parameter int INIT_PATTERN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_rw_i,
    input  logic [9:0]  mem_addr_i,
    input  logic [19:0] mem_wdata_i,
    output logic [19:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        busy_o,
    output logic [15:0] rd_count_o,
    output logic [15:0] wr_count_o
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [19:0] rdata_q, rdata_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        commit;
    logic        capture;

    logic        rw_q;
    logic [9:0]  addr_q;
    logic [9:0]  wdata_q;
    logic [9:0]  rd_word;

    // Words are stored XORed with their power-up value, so a zeroed array
    // reads back as the INIT_PATTERN image without a load phase.
    logic [9:0]  mem_q [0:1023] = '{default: '0};

    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^mem_wdata_i[19:10];

    function automatic logic [9:0] init_word(input logic [9:0] a);
        return (INIT_PATTERN != 0) ? a : 10'd0;
    endfunction

    assign rd_word = mem_q[addr_q] ^ init_word(addr_q);
    assign capture = (state_q == IDLE) && mem_req_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    ready_d = 1'b1;
                    if (rw_q) begin
                        commit   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end else begin
                        rdata_d  = {10'b0, rd_word};
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            rdata_q  <= 20'd0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Captured request; the live mem_* inputs are ignored once in WAIT.
    always_ff @(posedge clk) begin
        if (capture) begin
            rw_q    <= mem_rw_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[addr_q] <= wdata_q ^ init_word(addr_q);
        end
    end

    assign mem_rdata_o = rdata_q;
    assign mem_ready_o = ready_q;
    assign busy_o      = (state_q != IDLE);
    assign rd_count_o  = rd_cnt_q;
    assign wr_count_o  = wr_cnt_q;

endmodule

// File: tb/tb_backing_ram.sv
// Directed bench for backing_ram: table of single transactions plus
// hand-written burst, reset-abort and dropped-request sequences.
module tb_backing_ram;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [9:0]  addr = 10'd0;
    logic [19:0] wdata = 20'd0;
    logic [19:0] rdata;
    logic        ready;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    backing_ram #(.LATENCY(LAT), .INIT_PATTERN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req_i   (req),
        .mem_rw_i    (rw),
        .mem_addr_i  (addr),
        .mem_wdata_i (wdata),
        .mem_rdata_o (rdata),
        .mem_ready_o (ready),
        .busy_o      (busy),
        .rd_count_o  (rd_count),
        .wr_count_o  (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [9:0]  addr;
        logic [19:0] wdata;
        logic [19:0] exp_rdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge inside an IDLE cycle; returns the number of cycles
    // after capture until mem_ready was seen (0 on timeout).
    task automatic run_txn(input logic t_rw, input logic [9:0] t_addr,
                           input logic [19:0] t_wdata, input bit drop, output int lat);
        @(negedge clk);
        check("idle_ready", ready, 1'b0);
        check("idle_busy", busy, 1'b0);
        req   = 1'b1;
        rw    = t_rw;
        addr  = t_addr;
        wdata = t_wdata;
        lat   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (drop && n == 1) req = 1'b0;
            check("txn_busy", busy, 1'b1);
            if (ready) begin
                lat = n;
                break;
            end
        end
        req = 1'b0;
    endtask

    vec_t vecs[7];
    int   lat;
    int   gap;

    initial begin
        vecs[0] = '{1'b0, 10'd50,   20'h00000, 20'd50,    16'd1, 16'd0};
        vecs[1] = '{1'b1, 10'd50,   20'hFFC7B, 20'd50,    16'd1, 16'd1};
        vecs[2] = '{1'b0, 10'd50,   20'h00000, 20'h0007B, 16'd2, 16'd1};
        vecs[3] = '{1'b1, 10'd1023, 20'hAB000, 20'h0007B, 16'd2, 16'd2};
        vecs[4] = '{1'b0, 10'd1023, 20'h00000, 20'h00000, 16'd3, 16'd2};
        vecs[5] = '{1'b0, 10'd0,    20'h00000, 20'h00000, 16'd4, 16'd2};
        vecs[6] = '{1'b0, 10'd512,  20'h00000, 20'h00200, 16'd5, 16'd2};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 20'd0);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_count", rd_count, 16'd0);
        check("rst_wr_count", wr_count, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy_10", busy, 1'b0);
            check("idle_ready_10", ready, 1'b0);
        end

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), lat, LAT + 1);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rd_count", i), rd_count, vecs[i].exp_rd);
            check($sformatf("vec%0d_wr_count", i), wr_count, vecs[i].exp_wr);
        end

        // Cache-style burst: req held, address advanced during the ready cycle.
        @(negedge clk);
        req = 1'b1; rw = 1'b0; addr = 10'd100;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready) begin lat = n; break; end
        end
        check("burst0_latency", lat, LAT + 1);
        check("burst0_rdata", rdata, 20'd100);
        addr = 10'd101;
        gap = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready) begin gap = n; break; end
        end
        req = 1'b0;
        check("burst_gap", gap, LAT + 2);
        check("burst1_rdata", rdata, 20'd101);
        check("burst_rd_count", rd_count, 16'd7);

        // Reset while a write is in WAIT: the write must be abandoned.
        @(negedge clk);
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 10'd7; wdata = 20'h00155;
        @(negedge clk);
        check("abort_busy", busy, 1'b1);
        check("abort_ready", ready, 1'b0);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_rst", busy, 1'b0);
        check("abort_rd_count", rd_count, 16'd0);
        check("abort_rdata", rdata, 20'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_ready", ready, 1'b0);
            check("abort_wr_count", wr_count, 16'd0);
        end
        run_txn(1'b0, 10'd7, 20'h00000, 1'b0, lat);
        check("abort_rb_latency", lat, LAT + 1);
        check("abort_rb_rdata", rdata, 20'd7);
        check("abort_rb_wr_count", wr_count, 16'd0);
        check("abort_rb_rd_count", rd_count, 16'd1);

        // Request dropped during WAIT still completes.
        run_txn(1'b0, 10'd3, 20'h00000, 1'b1, lat);
        check("drop_latency", lat, LAT + 1);
        check("drop_rdata", rdata, 20'd3);
        check("drop_rd_count", rd_count, 16'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drop_idle_busy", busy, 1'b0);
            check("drop_idle_ready", ready, 1'b0);
        end
        check("final_rdata_hold", rdata, 20'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
